// File: rtl/max_window_ctrl.sv
// Measurement-window sequencer for the max_value peak datapath: clears it, gates its
// enable for a fixed count of accepted samples, waits out its latency, captures the peak.
module max_window_ctrl #(
    parameter int DATA_W       = 20,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_cfg_window,
    input  logic [DATA_W-1:0] i_cfg_baseline,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_max_in,
    output logic              o_max_clear,
    output logic              o_max_enable,
    output logic [DATA_W-1:0] o_baseline_value,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_sample_count,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic [DATA_W-1:0] o_result_data,
    output logic              o_result_above_base,
    output logic              o_cfg_err,
    output logic              o_sample_drop
);

    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_window_len;
    logic [CNT_W-1:0]  r_count;
    logic [DRW-1:0]    r_drain;
    logic [DATA_W-1:0] r_baseline;
    logic [DATA_W-1:0] r_result;
    logic              r_above;

    logic w_start_ok, w_accept, w_last_sample, w_drain_done;

    assign w_start_ok    = (r_state == S_IDLE) && i_start && (i_cfg_window != '0);
    // An abort cycle never counts as an accepted sample.
    assign w_accept      = (r_state == S_ACCUM) && i_sample_valid && !i_abort;
    assign w_last_sample = w_accept && (r_count == r_window_len - CNT_W'(1));
    assign w_drain_done  = (r_state == S_DRAIN) && (r_drain == DRW'(DRAIN_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_ACCUM;
            S_ACCUM:  if (w_last_sample) w_next = S_DRAIN;
            S_DRAIN:  if (w_drain_done) w_next = S_REPORT;
            S_REPORT: if (i_result_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (i_abort && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_window_len <= '0;
            r_count      <= '0;
            r_drain      <= '0;
            r_baseline   <= '0;
            r_result     <= '0;
            r_above      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_window_len <= i_cfg_window;
                r_baseline   <= i_cfg_baseline;
                r_count      <= '0;
            end
            if (w_accept) r_count <= r_count + CNT_W'(1);
            if (r_state == S_DRAIN && !w_drain_done) r_drain <= r_drain + DRW'(1);
            else                                     r_drain <= '0;
            if (w_drain_done && !i_abort) begin
                r_result <= i_max_in;
                r_above  <= (i_max_in > r_baseline);
            end
        end
    end

    always_comb begin
        o_max_clear         = (r_state == S_CLEAR);
        o_max_enable        = w_accept;
        o_busy              = (r_state != S_IDLE);
        o_result_valid      = (r_state == S_REPORT);
        o_cfg_err           = (r_state == S_IDLE) && i_start && (i_cfg_window == '0);
        o_sample_drop       = i_sample_valid && (r_state != S_ACCUM);
        o_baseline_value    = r_baseline;
        o_sample_count      = r_count;
        o_result_data       = r_result;
        o_result_above_base = r_above;
    end

endmodule

// File: tb/tb_max_window_ctrl.sv
// Directed + randomized bench for max_window_ctrl; a small max_value stand-in feeds max_in
// and the expected peak of each window is computed directly from the sample list.
module tb_max_window_ctrl;
    localparam int DATA_W = 20, CNT_W = 8, DRAIN_CYCLES = 1;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic              sample_valid = 1'b0, result_ready = 1'b0;
    logic [CNT_W-1:0]  cfg_window = '0;
    logic [DATA_W-1:0] cfg_baseline = '0, sample_in = '0, max_in;
    logic              max_clear, max_enable, busy, result_valid, result_above_base, cfg_err, sample_drop;
    logic [DATA_W-1:0] baseline_value, result_data;
    logic [CNT_W-1:0]  sample_count;

    int n_cmp = 0, n_bad = 0;
    logic [DATA_W-1:0] smp[$];
    int gapq[$];

    always #5 clk = ~clk;

    max_window_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_cfg_window(cfg_window), .i_cfg_baseline(cfg_baseline),
        .i_sample_valid(sample_valid), .i_max_in(max_in),
        .o_max_clear(max_clear), .o_max_enable(max_enable), .o_baseline_value(baseline_value),
        .o_busy(busy), .o_sample_count(sample_count), .o_result_valid(result_valid),
        .i_result_ready(result_ready), .o_result_data(result_data),
        .o_result_above_base(result_above_base), .o_cfg_err(cfg_err), .o_sample_drop(sample_drop)
    );

    // Stand-in for max_value: one-cycle registered running maximum, cleared to 0.
    logic [DATA_W-1:0] mv_q;
    always_ff @(posedge clk) begin
        if (rst || max_clear)                     mv_q <= '0;
        else if (max_enable && sample_in > mv_q)  mv_q <= sample_in;
    end
    assign max_in = mv_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_data"}, result_data, 0);
        check({tag, "_cnt"}, sample_count, 0);
        check({tag, "_base"}, baseline_value, 0);
        check({tag, "_above"}, result_above_base, 0);
        check({tag, "_clr"}, max_clear, 0);
        check({tag, "_en"}, max_enable, 0);
    endtask

    // Start cycle plus the CLEAR cycle; config inputs are scrambled once latched.
    task automatic begin_window(input int n, input logic [DATA_W-1:0] base);
        start = 1'b1; cfg_window = CNT_W'(n); cfg_baseline = base; sample_valid = 1'b0; settle();
        check("start_busy", busy, 0);
        check("start_cfg_err", cfg_err, 0);
        tick();
        start = 1'b0; cfg_window = CNT_W'($urandom); cfg_baseline = DATA_W'($urandom);
        sample_valid = 1'($urandom_range(0, 1)); sample_in = DATA_W'($urandom); settle();
        check("clear_pulse", max_clear, 1);
        check("clear_en", max_enable, 0);
        check("clear_drop", sample_drop, sample_valid);
        check("clear_base", baseline_value, base);
        check("clear_cnt", sample_count, 0);
        check("clear_busy", busy, 1);
        tick();
    endtask

    task automatic feed_samples(input int n);
        int g;
        for (int idx = 0; idx < n; idx++) begin
            if (gapq.size() > 0) g = gapq.pop_front();
            else g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            repeat (g) begin
                sample_valid = 1'b0; sample_in = DATA_W'($urandom); settle();
                check("gap_en", max_enable, 0);
                check("gap_cnt", sample_count, idx);
                tick();
            end
            sample_valid = 1'b1; sample_in = smp[idx]; settle();
            check("accum_en", max_enable, 1);
            check("accum_drop", sample_drop, 0);
            check("accum_clr", max_clear, 0);
            check("accum_cnt", sample_count, idx);
            tick();
        end
    endtask

    task automatic run_window(input int n, input logic [DATA_W-1:0] base, input int ready_wait);
        logic [DATA_W-1:0] expmax;
        expmax = '0;
        foreach (smp[i]) if (smp[i] > expmax) expmax = smp[i];
        begin_window(n, base);
        feed_samples(n);
        repeat (DRAIN_CYCLES) begin
            sample_valid = 1'($urandom_range(0, 1)); sample_in = DATA_W'($urandom); settle();
            check("drain_en", max_enable, 0);
            check("drain_drop", sample_drop, sample_valid);
            check("drain_valid", result_valid, 0);
            check("drain_cnt", sample_count, n);
            tick();
        end
        result_ready = 1'b0;
        repeat (ready_wait) begin
            start = 1'($urandom_range(0, 1)); sample_valid = 1'($urandom_range(0, 1)); settle();
            check("rep_valid", result_valid, 1);
            check("rep_data", result_data, expmax);
            check("rep_above", result_above_base, expmax > base);
            check("rep_cnt", sample_count, n);
            check("rep_drop", sample_drop, sample_valid);
            tick();
        end
        result_ready = 1'b1; start = 1'b1; sample_valid = 1'b0; settle();
        check("acc_valid", result_valid, 1);
        check("acc_data", result_data, expmax);
        check("acc_above", result_above_base, expmax > base);
        tick();
        result_ready = 1'b0; start = 1'b0; settle();
        check("post_valid", result_valid, 0);
        check("post_busy", busy, 0);
        check("post_clr", max_clear, 0);
        check("post_data", result_data, expmax);
        check("post_cnt", sample_count, n);
    endtask

    initial begin
        int n;
        rst = 1'b1; tick(); tick(); settle();
        check_idle_zero("reset");
        check("reset_cfg_err", cfg_err, 0);
        check("reset_drop", sample_drop, 0);
        rst = 1'b0; tick();

        // Basic five-sample window.
        smp = '{20'd10, 20'd15, 20'd20, 20'd35, 20'd8}; gapq = '{0, 0, 0, 0, 0};
        run_window(5, 20'd5, 0);

        // 24-sample window with trailing extras landing in DRAIN/REPORT.
        smp = '{20'd19876, 20'd8123, 20'd4567, 20'd777, 20'd12000, 20'd3, 20'd19875, 20'd600,
                20'd1500, 20'd9999, 20'd42, 20'd18000, 20'd7, 20'd1234, 20'd5678, 20'd900,
                20'd17000, 20'd256, 20'd4096, 20'd11111, 20'd175, 20'd176, 20'd501, 20'd2323};
        gapq.delete(); repeat (24) gapq.push_back(0);
        run_window(24, 20'd175, 2);

        // Gapped input, peak below baseline.
        smp = '{20'd1, 20'd0, 20'd2, 20'd9}; gapq = '{0, 1, 2, 0};
        run_window(4, 20'd10, 0);

        // Backpressure with start pulses during REPORT.
        smp.delete(); repeat (6) smp.push_back(DATA_W'($urandom)); gapq.delete();
        run_window(6, DATA_W'($urandom), 5);

        // Single-sample window and maximum-length window.
        smp = '{20'd77};
        run_window(1, 20'd77, 1);
        smp.delete(); repeat (255) smp.push_back(DATA_W'($urandom_range(0, 1000)));
        run_window(255, 20'd500, 0);

        // Randomized windows.
        repeat (8) begin
            n = $urandom_range(1, 12);
            smp.delete(); repeat (n) smp.push_back(DATA_W'($urandom));
            run_window(n, DATA_W'($urandom), $urandom_range(0, 3));
        end

        // Abort after 3 of 8 samples, with a sample offered in the abort cycle.
        smp = '{20'd4, 20'd5, 20'd6}; gapq = '{0, 0, 0};
        begin_window(8, 20'd1);
        feed_samples(3);
        abort = 1'b1; sample_valid = 1'b1; sample_in = 20'd999; settle();
        check("abort_en", max_enable, 0);
        check("abort_busy", busy, 1);
        tick();
        abort = 1'b0; sample_valid = 1'b0; settle();
        check("abort_idle", busy, 0);
        check("abort_valid", result_valid, 0);
        check("abort_clr", max_clear, 0);
        repeat (3) begin tick(); settle(); check("abort_novalid", result_valid, 0); end
        smp = '{20'd300, 20'd200}; gapq = '{0, 0};
        run_window(2, 20'd250, 1);

        // Reset during DRAIN discards the window.
        smp = '{20'd40, 20'd50, 20'd60}; gapq = '{0, 0, 0};
        begin_window(3, 20'd9);
        feed_samples(3);
        sample_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; settle();
        check_idle_zero("rst_drain");
        repeat (3) begin tick(); settle(); check("rst_novalid", result_valid, 0); end

        // Zero-length configuration.
        start = 1'b1; cfg_window = '0; cfg_baseline = 20'd3; settle();
        check("cfg0_err", cfg_err, 1);
        check("cfg0_busy", busy, 0);
        tick();
        start = 1'b0; settle();
        check("cfg0_err_pulse", cfg_err, 0);
        check("cfg0_busy2", busy, 0);
        check("cfg0_clr", max_clear, 0);
        tick(); settle();
        check("cfg0_clr2", max_clear, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
